mfp_usart_tx: RTL and testbench

MFP_USART_TX -- requirements
Module: mfp_usart_tx

---
 rtl/mfp_pkg.sv | 59 +++++
 rtl/mfp_usart_baud.sv | 36 +++
 rtl/mfp_usart_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_mfp_usart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_pkg.sv
// Shared definitions for the MFP USART transmitter: register bit positions,
// field encodings and FSM states. Build option MFP_USART_TX_PARITY_EN adds the PARITY state.
package mfp_pkg;

  localparam int UCR_DIV16 = 7;
  localparam int UCR_WL_HI = 6;
  localparam int UCR_WL_LO = 5;
  localparam int UCR_ST_HI = 4;
  localparam int UCR_ST_LO = 3;
  localparam int UCR_PE    = 2;
  localparam int UCR_EVEN  = 1;

  localparam int TSR_BE    = 7;
  localparam int TSR_UE    = 6;
  localparam int TSR_AT    = 5;
  localparam int TSR_END   = 4;
  localparam int TSR_B     = 3;
  localparam int TSR_HL_HI = 2;
  localparam int TSR_HL_LO = 1;
  localparam int TSR_TE    = 0;

  localparam logic [1:0] WL_8 = 2'b00;
  localparam logic [1:0] WL_7 = 2'b01;
  localparam logic [1:0] WL_6 = 2'b10;
  localparam logic [1:0] WL_5 = 2'b11;

  localparam logic [1:0] ST_SYNC = 2'b00;
  localparam logic [1:0] ST_1    = 2'b01;
  localparam logic [1:0] ST_1P5  = 2'b10;
  localparam logic [1:0] ST_2    = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef MFP_USART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } tx_state_e;

  // Stop length in half-bit strobes; in /1 mode a half strobe is a whole tick,
  // so 1.5 and 2 stop bits both round to two ticks.
  function automatic logic [2:0] stop_units(input logic div16, input logic [1:0] fmt);
    logic [2:0] u;
    if (div16) begin
      case (fmt)
        ST_1:    u = 3'd2;
        ST_1P5:  u = 3'd3;
        default: u = 3'd4;
      endcase
    end else begin
      u = (fmt == ST_1) ? 3'd1 : 3'd2;
    end
    return u;
  endfunction

endpackage

// File: rtl/mfp_usart_baud.sv
// Tick-to-bit-period divider: counts bit-clock ticks and flags bit and half-bit
// boundaries (every tick in /1 mode, every 16 / 8 ticks in /16 mode).
module mfp_usart_baud (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic div16,
  input  logic clr,
  output logic bit_stb,
  output logic half_stb
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (tick) begin
      cnt_d = div16 ? cnt_q + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_stb  = tick & (~div16 | (cnt_q == 4'hF));
  assign half_stb = tick & (~div16 | (cnt_q[2:0] == 3'h7));

endmodule

// File: rtl/mfp_usart_tx.sv
// MFP-style USART transmitter: buffer, shift register, framing FSM and status.
// Define MFP_USART_TX_PARITY_EN to enable the parity bit (UCR[2:1]).
module mfp_usart_tx
  import mfp_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TCLK_PULSE,
  input  logic       UCR_WE,
  input  logic [7:0] UCR_I,
  input  logic       UDR_WE,
  input  logic [7:0] UDR_I,
  input  logic       TSR_WE,
  input  logic [7:0] TSR_I,
  input  logic       TSR_RD,
  output logic [7:0] TSR_O,
  output logic [7:0] UCR_O,
  output logic       SO,
  output logic       TX_EMPTY_IRQ,
  output logic       TX_ERR_IRQ
);

  tx_state_e  state_q, state_d;
  logic [7:0] ucr_q, ucr_d, buf_q, buf_d, sh_q, sh_d;
  logic [5:0] tsr_lo_q, tsr_lo_d;
  logic       be_q, be_d, ue_q, ue_d, rd_q, so_q, so_d;
  logic [2:0] bit_cnt_q, bit_cnt_d, stop_cnt_q, stop_cnt_d;
  logic       sdiv16_q, sdiv16_d;
  logic [1:0] swl_q, swl_d, sst_q, sst_d;
  logic       empty_irq_q, empty_irq_d, err_irq_q, err_irq_d;
`ifdef MFP_USART_TX_PARITY_EN
  logic       spe_q, spe_d, par_q, par_d;
`endif
  logic       bit_stb, half_stb, baud_clr, do_load;
  logic       te, brk, idle_so, can_load;
  logic [2:0] nbits_m1;
  logic       tsr_hi_unused;

  assign tsr_hi_unused = ^TSR_I[7:6];

  mfp_usart_baud u_baud (
    .clk      (CLK),
    .rst_n    (RST_N),
    .tick     (TCLK_PULSE),
    .div16    (sdiv16_q),
    .clr      (baud_clr),
    .bit_stb  (bit_stb),
    .half_stb (half_stb)
  );

  assign te       = tsr_lo_q[TSR_TE];
  assign brk      = tsr_lo_q[TSR_B];
  assign idle_so  = te | (tsr_lo_q[TSR_HL_HI:TSR_HL_LO] != 2'b01);
  assign can_load = te & ~be_q & (ucr_q[UCR_ST_HI:UCR_ST_LO] != ST_SYNC);
  assign nbits_m1 = 3'd7 - {1'b0, swl_q};

  always_comb begin
    state_d     = state_q;
    ucr_d       = ucr_q;
    buf_d       = buf_q;
    sh_d        = sh_q;
    tsr_lo_d    = tsr_lo_q;
    be_d        = be_q;
    ue_d        = ue_q;
    so_d        = so_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    sdiv16_d    = sdiv16_q;
    swl_d       = swl_q;
    sst_d       = sst_q;
    empty_irq_d = 1'b0;
    err_irq_d   = 1'b0;
    baud_clr    = 1'b0;
    do_load     = 1'b0;
`ifdef MFP_USART_TX_PARITY_EN
    spe_d       = spe_q;
    par_d       = par_q;
`endif

    if (UCR_WE) ucr_d = UCR_I;
    if (TSR_WE) tsr_lo_d = TSR_I[5:0];
    if (rd_q)   ue_d = 1'b0;

    case (state_q)
      IDLE: begin
        so_d = idle_so;
        if (TCLK_PULSE) begin
          if (te & brk) begin
            state_d = BREAK;
            so_d    = 1'b0;
          end else if (can_load) begin
            do_load = 1'b1;
          end
        end
      end
      START: begin
        if (bit_stb) begin
          so_d      = sh_q[0];
          sh_d      = {1'b0, sh_q[7:1]};
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_stb) begin
          if (bit_cnt_q == nbits_m1) begin
            so_d       = 1'b1;
            stop_cnt_d = 3'd0;
            state_d    = STOP;
`ifdef MFP_USART_TX_PARITY_EN
            if (spe_q) begin
              so_d    = par_q;
              state_d = PARITY;
            end
`endif
          end else begin
            so_d      = sh_q[0];
            sh_d      = {1'b0, sh_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef MFP_USART_TX_PARITY_EN
      PARITY: begin
        if (bit_stb) begin
          so_d       = 1'b1;
          stop_cnt_d = 3'd0;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (half_stb) begin
          if ((stop_cnt_q + 3'd1) == stop_units(sdiv16_q, sst_q)) begin
            // Character boundary: disable, break, chain next word, or underrun.
            state_d = IDLE;
            so_d    = idle_so;
            if (!te) begin
              tsr_lo_d[TSR_END] = 1'b1;
            end else if (brk) begin
              state_d = BREAK;
              so_d    = 1'b0;
            end else if (can_load) begin
              do_load = 1'b1;
            end else if (be_q) begin
              ue_d      = 1'b1;
              err_irq_d = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 3'd1;
          end
        end
      end
      BREAK: begin
        so_d = 1'b0;
        if (TCLK_PULSE && !(te && brk)) begin
          state_d = IDLE;
          so_d    = idle_so;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame format is frozen here so UCR writes only affect later characters.
    if (do_load) begin
      state_d     = START;
      so_d        = 1'b0;
      sh_d        = buf_q;
      be_d        = 1'b1;
      empty_irq_d = 1'b1;
      baud_clr    = 1'b1;
      sdiv16_d    = ucr_q[UCR_DIV16];
      swl_d       = ucr_q[UCR_WL_HI:UCR_WL_LO];
      sst_d       = ucr_q[UCR_ST_HI:UCR_ST_LO];
`ifdef MFP_USART_TX_PARITY_EN
      spe_d       = ucr_q[UCR_PE];
      par_d       = (^(buf_q & (8'hFF >> ucr_q[UCR_WL_HI:UCR_WL_LO]))) ^ ~ucr_q[UCR_EVEN];
`endif
    end

    if (UDR_WE) begin
      buf_d = UDR_I;
      be_d  = 1'b0;
    end

    if (tsr_lo_d[TSR_TE]) tsr_lo_d[TSR_END] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ucr_q       <= 8'h00;
      buf_q       <= 8'h00;
      sh_q        <= 8'h00;
      tsr_lo_q    <= 6'h00;
      be_q        <= 1'b1;
      ue_q        <= 1'b0;
      rd_q        <= 1'b0;
      so_q        <= 1'b1;
      bit_cnt_q   <= 3'd0;
      stop_cnt_q  <= 3'd0;
      sdiv16_q    <= 1'b0;
      swl_q       <= WL_8;
      sst_q       <= ST_SYNC;
      empty_irq_q <= 1'b0;
      err_irq_q   <= 1'b0;
`ifdef MFP_USART_TX_PARITY_EN
      spe_q       <= 1'b0;
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ucr_q       <= ucr_d;
      buf_q       <= buf_d;
      sh_q        <= sh_d;
      tsr_lo_q    <= tsr_lo_d;
      be_q        <= be_d;
      ue_q        <= ue_d;
      rd_q        <= TSR_RD;
      so_q        <= so_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      sdiv16_q    <= sdiv16_d;
      swl_q       <= swl_d;
      sst_q       <= sst_d;
      empty_irq_q <= empty_irq_d;
      err_irq_q   <= err_irq_d;
`ifdef MFP_USART_TX_PARITY_EN
      spe_q       <= spe_d;
      par_q       <= par_d;
`endif
    end
  end

  assign TSR_O        = {be_q, ue_q, tsr_lo_q};
  assign UCR_O        = ucr_q;
  assign SO           = so_q;
  assign TX_EMPTY_IRQ = empty_irq_q;
  assign TX_ERR_IRQ   = err_irq_q;

endmodule

// File: tb/tb_mfp_usart_tx.sv
// Directed + randomized bench for mfp_usart_tx; expected serial streams come from
// a per-tick frame model built from the framing rules.
module tb_mfp_usart_tx;

  logic       CLK = 1'b0;
  logic       RST_N, TCLK_PULSE, UCR_WE, UDR_WE, TSR_WE, TSR_RD;
  logic [7:0] UCR_I, UDR_I, TSR_I;
  logic [7:0] TSR_O, UCR_O;
  logic       SO, TX_EMPTY_IRQ, TX_ERR_IRQ;

  int total = 0;
  int bad   = 0;
  int n_empty = 0;
  int n_err   = 0;

  logic       exp_q[$];
  logic [15:0] obs_bits;
  int         udr_at = -1, ucr_at = -1, tsr_at = -1;
  logic [7:0] udr_v, ucr_v, tsr_v;

  mfp_usart_tx dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .TCLK_PULSE   (TCLK_PULSE),
    .UCR_WE       (UCR_WE),
    .UCR_I        (UCR_I),
    .UDR_WE       (UDR_WE),
    .UDR_I        (UDR_I),
    .TSR_WE       (TSR_WE),
    .TSR_I        (TSR_I),
    .TSR_RD       (TSR_RD),
    .TSR_O        (TSR_O),
    .UCR_O        (UCR_O),
    .SO           (SO),
    .TX_EMPTY_IRQ (TX_EMPTY_IRQ),
    .TX_ERR_IRQ   (TX_ERR_IRQ)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (TX_EMPTY_IRQ === 1'b1) n_empty++;
    if (TX_ERR_IRQ === 1'b1) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_ucr(input logic [7:0] v);
    UCR_I = v; UCR_WE = 1'b1; @(negedge CLK); UCR_WE = 1'b0;
  endtask
  task automatic wr_udr(input logic [7:0] v);
    UDR_I = v; UDR_WE = 1'b1; @(negedge CLK); UDR_WE = 1'b0;
  endtask
  task automatic wr_tsr(input logic [7:0] v);
    TSR_I = v; TSR_WE = 1'b1; @(negedge CLK); TSR_WE = 1'b0;
  endtask

  task automatic do_tick();
    repeat ($urandom_range(0, 2)) @(negedge CLK);
    TCLK_PULSE = 1'b1;
    @(negedge CLK);
    TCLK_PULSE = 1'b0;
  endtask

  // Expected SO value after every tick of one character, starting at the load tick.
  task automatic push_frame(input logic [7:0] d, input logic [7:0] u);
    int n, nb, st;
    logic p;
    n  = u[7] ? 16 : 1;
    nb = 8 - int'(u[6:5]);
    repeat (n) exp_q.push_back(1'b0);
    for (int b = 0; b < nb; b++) repeat (n) exp_q.push_back(d[b]);
`ifdef MFP_USART_TX_PARITY_EN
    if (u[2]) begin
      p = 1'b0;
      for (int b = 0; b < nb; b++) p = p ^ d[b];
      if (!u[1]) p = ~p;
      repeat (n) exp_q.push_back(p);
    end
`else
    p = 1'b0;
`endif
    case (u[4:3])
      2'b01:   st = n;
      2'b10:   st = u[7] ? 24 : 2;
      default: st = 2 * n;
    endcase
    repeat (st) exp_q.push_back(1'b1);
  endtask

  task automatic run_q(input string tag);
    logic e;
    obs_bits = '0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == udr_at) wr_udr(udr_v);
      if (i == ucr_at) wr_ucr(ucr_v);
      if (i == tsr_at) wr_tsr(tsr_v);
      do_tick();
      e = exp_q.pop_front();
      obs_bits = {obs_bits[14:0], SO};
      check($sformatf("%s_so%0d", tag, i), 32'(SO), 32'(e));
    end
    udr_at = -1; ucr_at = -1; tsr_at = -1;
  endtask

  task automatic stop_end_ue(input string tag);
    int r0;
    r0 = n_err;
    do_tick();
    @(negedge CLK);
    check({tag, "_ue_set"}, 32'(TSR_O[6]), 32'd1);
    check({tag, "_err_irq"}, 32'(n_err - r0), 32'd1);
    TSR_RD = 1'b1; @(negedge CLK); TSR_RD = 1'b0;
    @(negedge CLK);
    check({tag, "_ue_clr"}, 32'(TSR_O[6]), 32'd0);
  endtask

  initial begin
    int e0;
    logic [7:0] d1, d2, u1, u2;
    RST_N = 1'b0; TCLK_PULSE = 1'b0; UCR_WE = 1'b0; UDR_WE = 1'b0; TSR_WE = 1'b0;
    TSR_RD = 1'b0; UCR_I = 8'h00; UDR_I = 8'h00; TSR_I = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_so", 32'(SO), 32'd1);
    check("rst_tsr", 32'(TSR_O), 32'h80);
    check("rst_ucr", 32'(UCR_O), 32'h00);
    check("rst_irq", 32'({TX_EMPTY_IRQ, TX_ERR_IRQ}), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // /1, 8N1, 0xA5
    wr_ucr(8'h08);
    wr_tsr(8'h01);
    check("ucr_rb", 32'(UCR_O), 32'h08);
    wr_udr(8'hA5);
    check("be_clr", 32'(TSR_O[7]), 32'd0);
    e0 = n_empty;
    push_frame(8'hA5, 8'h08);
    run_q("a5");
    check("a5_bits", 32'(obs_bits[9:0]), 32'(10'b0101001011));
    check("a5_be", 32'(TSR_O[7]), 32'd1);
    @(negedge CLK);
    check("a5_empty_irq", 32'(n_empty - e0), 32'd1);
    stop_end_ue("a5");

    // /16, 7 bits, even parity, 2 stop, 0x41
    wr_ucr(8'hBE);
    wr_udr(8'h41);
    push_frame(8'h41, 8'hBE);
    run_q("p41");
    stop_end_ue("p41");

    // Back-to-back characters with a mid-character format change
    for (int k = 0; k < 4; k++) begin
      d1 = 8'($urandom); d2 = 8'($urandom);
      u1 = {1'($urandom), 2'($urandom), 2'($urandom_range(1, 3)), 2'($urandom), 1'b0};
      u2 = {1'($urandom), 2'($urandom), 2'($urandom_range(1, 3)), 2'($urandom), 1'b0};
      wr_ucr(u1);
      push_frame(d1, u1);
      push_frame(d2, u2);
      udr_at = 3; udr_v = d2; ucr_at = 4; ucr_v = u2;
      wr_udr(d1);
      run_q($sformatf("b2b%0d", k));
      stop_end_ue($sformatf("b2b%0d", k));
    end

    // Break after the current character
    wr_ucr(8'h08);
    push_frame(8'h3C, 8'h08);
    tsr_at = 3; tsr_v = 8'h09;
    wr_udr(8'h3C);
    run_q("brk");
    do_tick();
    check("brk_so0", 32'(SO), 32'd0);
    do_tick();
    check("brk_so1", 32'(SO), 32'd0);
    wr_tsr(8'h01);
    do_tick();
    check("brk_exit", 32'(SO), 32'd1);

    // TE cleared mid-character, idle level, END
    push_frame(8'h96, 8'h08);
    tsr_at = 2; tsr_v = 8'h00;
    wr_udr(8'h96);
    run_q("te");
    do_tick();
    @(negedge CLK);
    check("te_so_idle", 32'(SO), 32'd1);
    check("te_end", 32'(TSR_O[4]), 32'd1);
    wr_tsr(8'h02);
    @(negedge CLK);
    check("hl01_so", 32'(SO), 32'd0);
    wr_tsr(8'h00);
    @(negedge CLK);
    check("hl00_so", 32'(SO), 32'd1);

    // Buffer overwrite while disabled, then enable
    wr_udr(8'h11);
    wr_udr(8'h22);
    check("ovw_be", 32'(TSR_O[7]), 32'd0);
    push_frame(8'h22, 8'h08);
    wr_tsr(8'h01);
    check("te_end_clr", 32'(TSR_O[4]), 32'd0);
    run_q("ovw");
    stop_end_ue("ovw");

    // Reset mid-DATA
    wr_udr(8'h00);
    repeat (3) do_tick();
    check("pre_rst_so", 32'(SO), 32'd0);
    RST_N = 1'b0;
    @(negedge CLK);
    check("mrst_so", 32'(SO), 32'd1);
    check("mrst_tsr", 32'(TSR_O), 32'h80);
    check("mrst_ucr", 32'(UCR_O), 32'h00);
    check("mrst_irq", 32'({TX_EMPTY_IRQ, TX_ERR_IRQ}), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
